fetch_queue: RTL and testbench

Instruction prefetch queue between the program counter / instruction cache and the decode stage. On every instruction-cache hit for the current fetch address it captures the instruction word with its PC and hands entries to decode in order through a valid/ready handshake. It back-pressures the program counter through `enable_pc` when it is full, and discards all contents on a branch/jump flush.

---
 rtl/fetch_queue.sv | 137 +++++++++++++
 tb/tb_fetch_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction prefetch queue between the program counter /
//             instruction cache and the decode stage. Every icache hit for
//             the current fetch PC is captured as {instr, pc} and handed to
//             decode in order through a valid/ready handshake. The PC is
//             held back through enable_pc while the queue is full, and a
//             branch/jump flush discards all queued instructions.
//  Ports    :
//    CLK          in   clock, rising edge
//    RST          in   synchronous active-high reset
//    ihit         in   icache returns the instruction for imemaddr
//    imemaddr     in   current fetch PC
//    imemload     in   instruction word (valid with ihit)
//    flush        in   redirect, drop everything
//    deq_ready    in   decode accepts the head entry
//    enable_pc    out  program counter may advance on ihit
//    imemREN      out  instruction read request
//    instr_valid  out  head entry valid
//    instr        out  head instruction word
//    instr_pc     out  PC of head instruction
//    instr_npc    out  instr_pc + 4
//    count        out  number of occupied entries
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       ihit,
   input  logic [31:0]                imemaddr,
   input  logic [31:0]                imemload,
   input  logic                       flush,
   input  logic                       deq_ready,
   output logic                       enable_pc,
   output logic                       imemREN,
   output logic                       instr_valid,
   output logic [31:0]                instr,
   output logic [31:0]                instr_pc,
   output logic [31:0]                instr_npc,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
   localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

   // Storage is intentionally not reset; only pointers and count are.
   logic [31:0]   r_mem_instr [DEPTH];
   logic [31:0]   r_mem_pc    [DEPTH];

   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_not_empty;
   logic          w_not_full;
   logic          w_pop;
   logic          w_push;
   logic          w_enable_pc;

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   assign w_not_empty = (r_count != '0);
   assign w_not_full  = (r_count < C_DEPTH);

   // A pop only happens on a valid head and never during a flush.
   assign w_pop       = deq_ready & w_not_empty & ~flush;

   // When full, a same-cycle pop frees a slot, so the PC may still advance.
   assign w_enable_pc = ~RST & ~flush & (w_not_full | w_pop);

   // enable_pc already folds in RST and flush, so push is blocked in both.
   assign w_push      = ihit & w_enable_pc;

   assign enable_pc   = w_enable_pc;
   assign imemREN     = ~RST & ~flush;

   // ------------------------------------------------------------------------
   // Pointers and occupancy
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Entry storage. On a full push+pop the write pointer equals the read
   // pointer; the write lands in the slot the pop is vacating this edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem_instr[r_wr_ptr] <= imemload;
         r_mem_pc[r_wr_ptr]    <= imemaddr;
      end
   end

   // ------------------------------------------------------------------------
   // Head outputs: purely from state. An empty queue presents zeros so
   // downstream sees a clean instr_pc of 0 and instr_npc of 4.
   // ------------------------------------------------------------------------
   always_comb begin
      instr    = 32'd0;
      instr_pc = 32'd0;
      if (w_not_empty) begin
         instr    = r_mem_instr[r_rd_ptr];
         instr_pc = r_mem_pc[r_rd_ptr];
      end
   end

   // 32-bit wrap-around: 0xFFFFFFFC + 4 yields 0.
   assign instr_npc   = instr_pc + 32'd4;
   assign instr_valid = w_not_empty;
   assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Directed self-checking bench for fetch_queue (DEPTH = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit;
   logic [31:0] imemaddr;
   logic [31:0] imemload;
   logic        flush;
   logic        deq_ready;
   logic        enable_pc;
   logic        imemREN;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_npc;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   fetch_queue #(.DEPTH(4)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .ihit        (ihit),
      .imemaddr    (imemaddr),
      .imemload    (imemload),
      .flush       (flush),
      .deq_ready   (deq_ready),
      .enable_pc   (enable_pc),
      .imemREN     (imemREN),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_npc   (instr_npc),
      .count       (count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Occupancy must never exceed DEPTH once out of the first reset.
   always @(negedge CLK) begin
      if (!$isunknown(count)) begin
         checks++;
         assert (count <= 3'd4) else begin
            errors++;
            $error("FAIL count_bound observed %0d expected <=4", count);
         end
      end
   end

   // Advance one edge, then let registered outputs settle.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] ld(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   initial begin
      RST = 1'b1; ihit = 1'b1; imemaddr = 32'h0; imemload = 32'h0;
      flush = 1'b0; deq_ready = 1'b0;

      // ---------------- reset held for two cycles with ihit high ----------
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_count",     32'(count),       32'd0);
         chk("rst_valid",     32'(instr_valid), 32'd0);
         chk("rst_enable_pc", 32'(enable_pc),   32'd0);
         chk("rst_imemREN",   32'(imemREN),     32'd0);
         chk("rst_instr",     instr,            32'd0);
         chk("rst_instr_pc",  instr_pc,         32'd0);
      end
      RST = 1'b0; ihit = 1'b0;
      #1;
      chk("post_rst_enable_pc", 32'(enable_pc), 32'd1);
      chk("post_rst_imemREN",   32'(imemREN),   32'd1);
      chk("empty_npc",          instr_npc,      32'd4);

      // ---------------- fill 0x0..0xC ----------------
      for (int i = 0; i < 4; i++) begin
         ihit = 1'b1; imemaddr = 32'(4 * i); imemload = ld(32'(4 * i));
         #1;
         chk("fill_enable_pc", 32'(enable_pc), 32'd1);
         tick();
         chk("fill_count", 32'(count), 32'(i + 1));
         chk("fill_head_pc", instr_pc, 32'h0);
      end
      chk("fill_head_instr", instr, ld(32'h0));
      // fifth fetch is blocked
      imemaddr = 32'h10; imemload = ld(32'h10);
      #1;
      chk("full_enable_pc", 32'(enable_pc), 32'd0);
      tick();
      chk("full_count_hold", 32'(count), 32'd4);
      chk("full_head_pc", instr_pc, 32'h0);

      // ---------------- push+pop while full ----------------
      deq_ready = 1'b1;
      #1;
      chk("fullpp_enable_pc", 32'(enable_pc), 32'd1);
      tick();
      chk("fullpp_count", 32'(count), 32'd4);
      chk("fullpp_head_pc", instr_pc, 32'h4);

      // ---------------- drain: 4, 8, C, 10 ----------------
      ihit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", 32'(instr_valid), 32'd1);
         chk("drain_pc",    instr_pc,  32'(4 * i + 4));
         chk("drain_npc",   instr_npc, 32'(4 * i + 8));
         chk("drain_instr", instr,     ld(32'(4 * i + 4)));
         chk("drain_count", 32'(count), 32'(4 - i));
         tick();
      end
      chk("drained_valid", 32'(instr_valid), 32'd0);
      chk("drained_count", 32'(count),       32'd0);
      chk("drained_pc",    instr_pc,         32'd0);
      chk("drained_npc",   instr_npc,        32'd4);

      // ---------------- empty corner: push + pop request while empty ------
      ihit = 1'b1; imemaddr = 32'h20; imemload = ld(32'h20);
      #1;
      chk("empty_enable_pc", 32'(enable_pc), 32'd1);
      tick();
      chk("empty_count", 32'(count),       32'd1);
      chk("empty_valid", 32'(instr_valid), 32'd1);
      chk("empty_pc",    instr_pc,         32'h20);

      // ---------------- build up to three entries ----------------
      deq_ready = 1'b0;
      imemaddr = 32'h24; imemload = ld(32'h24);
      tick();
      imemaddr = 32'h28; imemload = ld(32'h28);
      tick();
      chk("pre_flush_count", 32'(count), 32'd3);
      chk("pre_flush_pc",    instr_pc,   32'h20);

      // ---------------- flush with ihit and deq_ready ----------------
      flush = 1'b1; deq_ready = 1'b1; imemaddr = 32'h2C; imemload = ld(32'h2C);
      #1;
      chk("flush_enable_pc", 32'(enable_pc), 32'd0);
      chk("flush_imemREN",   32'(imemREN),   32'd0);
      tick();
      chk("flush_count", 32'(count),       32'd0);
      chk("flush_valid", 32'(instr_valid), 32'd0);
      flush = 1'b0; deq_ready = 1'b0;

      // ---------------- restart after flush ----------------
      imemaddr = 32'h30; imemload = ld(32'h30);
      tick();
      chk("restart_count", 32'(count), 32'd1);
      chk("restart_pc",    instr_pc,   32'h30);
      chk("restart_instr", instr,      ld(32'h30));

      // ---------------- npc wrap with simultaneous push+pop ----------------
      deq_ready = 1'b1; imemaddr = 32'hFFFF_FFFC; imemload = 32'hDEAD_BEEF;
      tick();
      chk("wrap_count", 32'(count), 32'd1);
      chk("wrap_pc",    instr_pc,   32'hFFFF_FFFC);
      chk("wrap_npc",   instr_npc,  32'h0);
      chk("wrap_instr", instr,      32'hDEAD_BEEF);

      // ---------------- mid-operation reset ----------------
      deq_ready = 1'b0; imemaddr = 32'h40; RST = 1'b1;
      #1;
      chk("midrst_enable_pc", 32'(enable_pc), 32'd0);
      chk("midrst_imemREN",   32'(imemREN),   32'd0);
      tick();
      chk("midrst_count", 32'(count),       32'd0);
      chk("midrst_valid", 32'(instr_valid), 32'd0);
      chk("midrst_pc",    instr_pc,         32'd0);
      RST = 1'b0; ihit = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
